// File: rtl/button_debouncer_pkg.sv
// Shared types and helpers for the pushbutton debouncer: FSM state encoding
// and the counter-width function.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;

  // Smallest r with 2**r >= value.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'(1) << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with a configurable reset value, for bringing
// asynchronous board inputs into the clock domain.
module sync_2ff #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Pushbutton conditioner: synchronise, debounce with a counter-driven FSM, and
// emit a debounced level plus one-cycle press/release pulses.
// Optional auto-repeat of press_o while held: define BUTTON_DEBOUNCER_AUTOREPEAT_EN.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 120000,
  parameter int unsigned BUTTON_ACTIVE_LOW = 1,
  parameter int unsigned REPEAT_DELAY      = 6000000,
  parameter int unsigned REPEAT_PERIOD     = 1200000
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic button_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned     CNT_W        = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic            PIN_RELEASED = (BUTTON_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic pin_sync;
  logic s_c;

  // Synchroniser resets to the released pin level so reset never looks like a press.
  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (PIN_RELEASED)
  ) u_sync (
    .clk   (clock_i),
    .rst_n (reset_n_i),
    .d_i   (button_i),
    .q_o   (pin_sync)
  );

  assign s_c = (pin_sync != PIN_RELEASED);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             accept_press_c;
  logic             accept_release_c;

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_first_q, rpt_first_d;
`else
  logic unused_rpt_c;
  assign unused_rpt_c = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  // State, counter and registered outputs.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_RELEASED;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
`endif
    end
  end

  // Next state and debounce counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RELEASED: begin
        if (s_c) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_PRESS_WAIT: begin
        if (!s_c) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!s_c) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        if (s_c) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs change on the same edge as the accepting state transition.
  always_comb begin
    accept_press_c   = (state_q == ST_PRESS_WAIT)   && (state_d == ST_HELD);
    accept_release_c = (state_q == ST_RELEASE_WAIT) && (state_d == ST_RELEASED);
    level_d          = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
    press_d          = accept_press_c;
    release_d        = accept_release_c;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    rpt_d       = '0;
    rpt_first_d = 1'b1;
    // Keeps counting through a rejected release bounce; suppressed on the release edge.
    if (!accept_press_c && state_d != ST_RELEASED &&
        (state_q == ST_HELD || state_q == ST_RELEASE_WAIT)) begin
      rpt_first_d = rpt_first_q;
      if (rpt_q == (rpt_first_q ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
        rpt_d       = '0;
        rpt_first_d = 1'b0;
        press_d     = 1'b1;
      end else begin
        rpt_d = rpt_q + RPT_W'(1);
      end
    end
`endif
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (DEBOUNCE_CYCLES=8, active-low pin,
// repeat delay/period 20/5).
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst_n;
  logic button;
  logic level;
  logic press;
  logic rel;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES   (8),
    .BUTTON_ACTIVE_LOW (1),
    .REPEAT_DELAY      (20),
    .REPEAT_PERIOD     (5)
  ) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .button_i  (button),
    .level_o   (level),
    .press_o   (press),
    .release_o (rel)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    button = 1'b1;
    for (int i = 0; i < 6; i++) begin
      button = (i % 2 == 0) ? 1'b0 : 1'b1;
      step();
      n_tests++;
      if ({level, press, rel} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_held cycle %0d: got %b%b%b expected 000", i, level, press, rel);
      end
    end
    button = 1'b1;
    rst_n  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_tests++;
      if ({level, press, rel} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got %b%b%b expected 000", i, level, press, rel);
      end
    end
  endtask

  task automatic test_clean_press();
    button = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      n_tests++;
      if (press !== (k == 10) || level !== (k >= 10) || rel !== 1'b0) begin
        n_fail++;
        $display("FAIL clean_press cycle %0d: got lvl=%b prs=%b rel=%b expected lvl=%b prs=%b rel=0",
                 k, level, press, rel, (k >= 10), (k == 10));
      end
    end
  endtask

  task automatic test_release_glitch();
    button = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 3) button = 1'b0;
      n_tests++;
      if (level !== 1'b1 || rel !== 1'b0) begin
        n_fail++;
        $display("FAIL release_glitch cycle %0d: got lvl=%b rel=%b expected lvl=1 rel=0",
                 k, level, rel);
      end
    end
  endtask

  task automatic test_clean_release(input string tag);
    button = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      n_tests++;
      if (rel !== (k == 10) || level !== (k < 10)) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got lvl=%b rel=%b expected lvl=%b rel=%b",
                 tag, k, level, rel, (k < 10), (k == 10));
      end
      if (k >= 10) begin
        n_tests++;
        if (press !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_nopress cycle %0d: got prs=%b expected prs=0", tag, k, press);
        end
      end
    end
  endtask

  task automatic test_bounce();
    button = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k == 5) button = 1'b1;
      if (k == 8) button = 1'b0;
      n_tests++;
      if (press !== (k == 18) || level !== (k >= 18) || rel !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce cycle %0d: got lvl=%b prs=%b rel=%b expected lvl=%b prs=%b rel=0",
                 k, level, press, rel, (k >= 18), (k == 18));
      end
    end
  endtask

  task automatic test_mid_reset();
    button = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      n_tests++;
      if (press !== 1'b0 || level !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_pre cycle %0d: got lvl=%b prs=%b expected 0 0", k, level, press);
      end
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({level, press, rel} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset_assert: got %b%b%b expected 000", level, press, rel);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_tests++;
      if (press !== (k == 10) || level !== (k >= 10) || rel !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_post cycle %0d: got lvl=%b prs=%b rel=%b expected lvl=%b prs=%b rel=0",
                 k, level, press, rel, (k >= 10), (k == 10));
      end
    end
  endtask

  task automatic test_autorepeat();
    logic exp_press;
    test_clean_release("ar_release");
    button = 1'b0;
    for (int k = 1; k <= 59; k++) begin
      step();
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
      exp_press = (k == 10) || (k >= 30 && k <= 55 && ((k - 30) % 5) == 0);
`else
      exp_press = (k == 10);
`endif
      n_tests++;
      if (press !== exp_press || level !== (k >= 10) || rel !== 1'b0) begin
        n_fail++;
        $display("FAIL autorepeat cycle %0d: got lvl=%b prs=%b rel=%b expected lvl=%b prs=%b rel=0",
                 k, level, press, rel, (k >= 10), exp_press);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    button = 1'b1;
    test_reset();
    test_clean_press();
    test_release_glitch();
    test_clean_release("clean_release");
    test_bounce();
    test_clean_release("release_after_bounce");
    test_mid_reset();
    test_autorepeat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
